// File: rtl/conv_pix_src.sv
// Frame pixel source: reads one IMG_W x IMG_H frame in raster order and streams it with sof/eol/eof markers.
// Optional test-pattern mode via CONV_PIX_SRC_TEST_PATTERN_EN (adds tp_sel, pixel = {row[7:0], col[7:0]}).
module conv_pix_src #(
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned HBLANK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef CONV_PIX_SRC_TEST_PATTERN_EN
    input  logic              tp_sel,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       pix_data,
    output logic              pix_en,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned HB_W  = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    typedef enum logic [1:0] {IDLE, LINE, BLANK, DRAIN} state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [HB_W-1:0]   hb_q, hb_d;
    logic              start_acc;

    logic              inf_v;
    pix_t              inf_q;
    logic              head_v, tail_v;
    pix_t              head_q, tail_q;
    pix_t              cur_ent, push_ent;

    logic              pop, room, issue;
    logic [2:0]        occ;
    logic              tp_q;

`ifdef CONV_PIX_SRC_TEST_PATTERN_EN
    // Pattern select is frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         tp_q <= 1'b0;
        else if (start_acc) tp_q <= tp_sel;
    end
`else
    assign tp_q = 1'b0;
`endif

    assign pix_en   = head_v;
    assign pix_data = head_q.data;
    assign pix_sof  = head_q.sof;
    assign pix_eol  = head_q.eol;
    assign pix_eof  = head_q.eof;

    // Issue only when the buffer can absorb everything already requested plus this read.
    always_comb begin
        pop       = head_v & pix_ready;
        occ       = 3'(head_v) + 3'(tail_v) + 3'(inf_v);
        room      = pop ? (occ < 3'd3) : (occ < 3'd2);
        issue     = (state_q == LINE) && room;
        mem_rd_en = issue & ~tp_q;
        done      = (state_q == DRAIN) && pop && head_q.eof;

        cur_ent.data = {8'(row_q), 8'(col_q)};
        cur_ent.sof  = (row_q == '0) && (col_q == '0);
        cur_ent.eol  = (col_q == COL_W'(IMG_W - 1));
        cur_ent.eof  = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));

        push_ent = inf_q;
        if (!tp_q) push_ent.data = mem_rdata;
    end

    // Next-state: raster walk with per-line blanking and a final drain.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        hb_d      = hb_q;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = LINE;
                    col_d     = '0;
                    row_d     = '0;
                end
            end
            LINE: begin
                if (issue) begin
                    if (col_q == COL_W'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(IMG_H - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            hb_d    = '0;
                            state_d = (HBLANK == 0) ? LINE : BLANK;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            BLANK: begin
                hb_d = hb_q + HB_W'(1);
                if (hb_q == HB_W'(HBLANK - 1)) state_d = LINE;
            end
            DRAIN: begin
                if (pop && head_q.eof) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            hb_q     <= '0;
            mem_addr <= '0;
            busy     <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hb_q    <= hb_d;
            if (start_acc)  mem_addr <= base_addr;
            else if (issue) mem_addr <= mem_addr + ADDR_W'(1);
            if (start_acc)  busy <= 1'b1;
            else if (done)  busy <= 1'b0;
        end
    end

    // One-deep read pipeline followed by a head/tail two-entry buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inf_v  <= 1'b0;
            inf_q  <= '0;
            head_v <= 1'b0;
            head_q <= '0;
            tail_v <= 1'b0;
            tail_q <= '0;
        end else begin
            inf_v <= issue;
            if (issue) inf_q <= cur_ent;
            if (pop) begin
                if (tail_v) begin
                    head_q <= tail_q;
                    tail_v <= inf_v;
                    if (inf_v) tail_q <= push_ent;
                end else begin
                    head_v <= inf_v;
                    if (inf_v) head_q <= push_ent;
                end
            end else if (inf_v) begin
                if (!head_v) begin
                    head_v <= 1'b1;
                    head_q <= push_ent;
                end else begin
                    tail_v <= 1'b1;
                    tail_q <= push_ent;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pix_src.sv
// Scoreboard bench for conv_pix_src at IMG_W=4, IMG_H=3, HBLANK=2.
module tb_conv_pix_src;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          tp_sel = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata = 16'hDEAD;
    logic [15:0]   pix_data;
    logic          pix_en;
    logic          pix_ready = 1'b1;
    logic          pix_sof, pix_eol, pix_eof, busy, done;

    conv_pix_src #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .HBLANK(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
`ifdef CONV_PIX_SRC_TEST_PATTERN_EN
        .tp_sel(tp_sel),
`endif
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_en(pix_en), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory returns the low 16 address bits one cycle after the strobe.
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem_addr[15:0] : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk = 0, n_fail = 0;
    logic [18:0] exp_q[$];
    int start_cyc = 0, n_rd = 0, n_pop = 0;
    int rd_log[$];
    int first_en = -1, done_rel = -1, busy_fall = -1;
    bit busy_seen = 0, rnd_ready = 0;
    bit stall_prev = 0;
    logic [15:0] stall_data;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pop the scoreboard on every transfer and watch protocol invariants.
    always @(negedge clk) begin
        logic [18:0] e;
        int rel;
        if (!rst_n) begin
            stall_prev = 0;
            n_rd = 0;
            n_pop = 0;
        end else begin
            rel = cyc - start_cyc;
            if (stall_prev)
                check(pix_en && pix_data == stall_data, "stall_hold", {15'd0, pix_en, pix_data}, {16'd1, stall_data});
            stall_prev = pix_en && !pix_ready;
            stall_data = pix_data;
            if (pix_en && pix_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_pix", {16'd0, pix_data}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({pix_data, pix_sof, pix_eol, pix_eof, done} == {e, e[0]}, "pixel",
                          {12'd0, pix_data, pix_sof, pix_eol, pix_eof, done}, {12'd0, e, e[0]});
                end
            end else begin
                check(done == 1'b0, "done_no_xfer", {31'd0, done}, 32'd0);
            end
            if (mem_rd_en) begin
                n_rd++;
                rd_log.push_back(rel);
            end
            check((n_rd - n_pop) <= 2, "outstanding", n_rd - n_pop, 32'd2);
            if (pix_en && first_en < 0) first_en = rel;
            if (done) done_rel = rel;
            if (busy) busy_seen = 1;
            if (busy_seen && !busy && busy_fall < 0) busy_fall = rel;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) pix_ready = 1'($urandom_range(0, 1));
    end

    task automatic push_frame(input logic [AW-1:0] b, input bit tp);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                logic [15:0] d;
                logic [AW-1:0] a;
                a = b + AW'(r * W + c);
                d = tp ? {8'(r), 8'(c)} : a[15:0];
                exp_q.push_back({d, r == 0 && c == 0, c == W - 1, c == W - 1 && r == H - 1});
            end
    endtask

    task automatic begin_frame();
        rd_log.delete();
        first_en = -1;
        done_rel = -1;
        busy_fall = -1;
        busy_seen = 0;
        n_rd = 0;
        n_pop = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_at(input int rel, input logic [AW-1:0] b);
        while ((cyc - start_cyc) < rel) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(!busy, name, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check({mem_rd_en, mem_addr, pix_en, pix_data, pix_sof, pix_eol, pix_eof, busy, done} == '0, name,
              {mem_rd_en, pix_en, pix_sof, pix_eol, pix_eof, busy, done, 9'd0, pix_data}, 32'd0);
        check(mem_addr == '0, {name, "_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        int exp_rd[12];
        exp_rd = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};

        #23;
        check_idle_outputs("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Nominal frame with full throughput.
        begin_frame();
        push_frame(19'h100, 0);
        pulse_start(19'h100);
        wait_idle("t1_busy_timeout");
        check(exp_q.size() == 0, "t1_leftover", exp_q.size(), 32'd0);
        check(rd_log.size() == 12, "t1_read_count", rd_log.size(), 32'd12);
        for (int i = 0; i < 12 && i < rd_log.size(); i++)
            check(rd_log[i] == exp_rd[i], "t1_read_cycle", rd_log[i], exp_rd[i]);
        check(first_en == 3, "t1_first_pix_en", first_en, 32'd3);
        check(done_rel == 18, "t1_done_cycle", done_rel, 32'd18);
        check(busy_fall == 19, "t1_busy_fall", busy_fall, 32'd19);

        // Random backpressure.
        begin_frame();
        push_frame(19'h100, 0);
        rnd_ready = 1;
        pulse_start(19'h100);
        wait_idle("t2_busy_timeout");
        rnd_ready = 0;
        #1 pix_ready = 1'b1;
        check(exp_q.size() == 0, "t2_leftover", exp_q.size(), 32'd0);

        // Long stall right after start.
        begin_frame();
        push_frame(19'h100, 0);
        pix_ready = 1'b0;
        pulse_start(19'h100);
        while ((cyc - start_cyc) < 20) @(negedge clk);
        check(n_rd == 2, "t3_stalled_reads", n_rd, 32'd2);
        check(pix_en && pix_data == 16'h0100, "t3_stalled_head", {15'd0, pix_en, pix_data}, 32'h10100);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        wait_idle("t3_busy_timeout");
        check(exp_q.size() == 0, "t3_leftover", exp_q.size(), 32'd0);

        // Starts while busy, including in the done cycle, are ignored.
        begin_frame();
        push_frame(19'h100, 0);
        pulse_start(19'h100);
        start_at(8, 19'h500);
        start_at(18, 19'h600);
        wait_idle("t4_busy_timeout");
        check(done_rel == 18, "t4_done_cycle", done_rel, 32'd18);
        repeat (5) @(negedge clk);
        check(!busy && !mem_rd_en, "t4_no_restart", {30'd0, busy, mem_rd_en}, 32'd0);
        check(exp_q.size() == 0, "t4_leftover", exp_q.size(), 32'd0);
        begin_frame();
        push_frame(19'h300, 0);
        pulse_start(19'h300);
        wait_idle("t4b_busy_timeout");
        check(exp_q.size() == 0, "t4b_leftover", exp_q.size(), 32'd0);

        // Reset mid-frame, then a clean frame.
        begin_frame();
        push_frame(19'h100, 0);
        pulse_start(19'h100);
        for (int i = 0; i < 100 && n_pop < 6; i++) @(negedge clk);
        check(n_pop == 6, "t5_reach_pix6", n_pop, 32'd6);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("t5_reset_outputs");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check(done_rel == -1, "t5_no_done", done_rel, 32'hFFFFFFFF);
        begin_frame();
        push_frame(19'h100, 0);
        pulse_start(19'h100);
        wait_idle("t5_busy_timeout");
        check(exp_q.size() == 0, "t5_leftover", exp_q.size(), 32'd0);
        check(first_en == 3, "t5_first_pix_en", first_en, 32'd3);

`ifdef CONV_PIX_SRC_TEST_PATTERN_EN
        // Test pattern: no memory traffic, same timing.
        begin_frame();
        push_frame(19'h100, 1);
        tp_sel = 1'b1;
        pulse_start(19'h100);
        tp_sel = 1'b0;
        wait_idle("t6_busy_timeout");
        check(n_rd == 0, "t6_no_mem_reads", n_rd, 32'd0);
        check(exp_q.size() == 0, "t6_leftover", exp_q.size(), 32'd0);
        check(first_en == 3, "t6_first_pix_en", first_en, 32'd3);
        check(done_rel == 18, "t6_done_cycle", done_rel, 32'd18);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_pix_src.md
Name: conv_pix_src

Overview:
Frame pixel source that feeds the 3x3 convolution pipeline's pixel input. On a start pulse it reads one IMG_W x IMG_H frame of 16-bit grey pixels from a synchronous frame memory in raster order. It emits the pixels as a valid/ready stream with frame and line markers. Programmable horizontal blanking between lines gives the line-buffer/matrix stage its row turnaround gaps.

Parameters:
IMG_W, 640, pixels per line (>=2)
IMG_H, 480, lines per frame (>=2)
ADDR_W, 19, frame memory address width
HBLANK, 4, idle cycles between the last read of a line and the first read of the next line (0 = back-to-back)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset
start  in  1  single-cycle frame request
base_addr  in  ADDR_W  frame base address, latched on accepted start
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  16  read data, valid exactly 1 cycle after mem_rd_en
pix_data  out  16  pixel to convolution input
pix_en  out  1  pixel valid
pix_ready  in  1  downstream accept
pix_sof  out  1  qualifies the first pixel of the frame
pix_eol  out  1  qualifies the last pixel of each line
pix_eof  out  1  qualifies the last pixel of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs reset to 0. Counters reset to 0, the output buffer is emptied, and the FSM goes to IDLE. Reset mid-frame abandons the frame and asserts no done. Read data arriving in the first cycle after reset release is discarded.
- FSM states: IDLE, LINE, BLANK, DRAIN.
  - IDLE: start=1 latches base_addr and clears row/col; next state LINE. busy=1 from the following cycle.
  - LINE: issues reads for col 0..IMG_W-1 at addresses base+row*IMG_W+col, as a linear increment.
  - After the last col of a row that is not the last row: go to BLANK for HBLANK cycles, then LINE with row+1. If HBLANK=0, go straight to LINE.
  - After the last read of the last row: go to DRAIN. Stay there until the eof pixel is transferred, then go to IDLE.
  - done pulses 1 cycle in the transfer cycle of the eof pixel. busy drops the cycle after.
- start while busy is ignored, including in the done cycle.
- Read issue rule:
  - A read is issued in a cycle only if (buffer occupancy + reads in flight − pop this cycle) < 2.
  - An internal 2-entry FIFO holds {data, sof, eol, eof}. No pixel is ever lost or duplicated under any pix_ready pattern.
  - In BLANK and DRAIN, mem_rd_en=0. The BLANK cycle count runs regardless of backpressure.
- Output stream:
  - pix_en = FIFO non-empty. pix_data and the markers show the head entry.
  - A transfer happens when pix_en & pix_ready. pix_data is held stable while pix_en=1 & pix_ready=0.
- Latency with pix_ready=1: start in cycle 0, first mem_rd_en in cycle 1, first pix_en in cycle 3. Throughput is 1 pixel/cycle inside a line.
- Markers: pix_sof on pixel (0,0). pix_eol on col IMG_W−1 of every row. pix_eof on (IMG_H−1, IMG_W−1), together with pix_eol.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.

Optional Feature:
CONV_PIX_SRC_TEST_PATTERN_EN
- Defined: adds input port tp_sel (1 bit), sampled with start and held for the frame. With tp_sel=1, mem_rd_en stays 0 and each pixel's data is {row[7:0], col[7:0]}. Timing, markers, backpressure and blanking are identical to memory mode, with the pattern word taking the place of the 1-cycle read.
- Undefined: no tp_sel port; data always comes from mem_rdata.

Test Plan:
- IMG_W=4, IMG_H=3, HBLANK=2, base=0x100, memory returns addr[15:0], pix_ready=1 -> 12 pixels 0x100..0x10B in order. First pix_en 3 cycles after start. Exactly 2 idle read cycles between lines. sof on 0x100, eol on 0x103/0x107/0x10B, eof+done on 0x10B.
- Same config, pix_ready toggling 1/0 pseudo-randomly -> identical 12-word sequence. mem_rd_en never creates more than 2 outstanding-plus-buffered entries. pix_data stable while stalled.
- pix_ready=0 for 20 cycles after start -> exactly 2 reads issued, pix_en=1 holding 0x100. On release the stream resumes without gaps or loss.
- Second start pulse mid-frame and in the done cycle -> ignored. Base latched once. Next start after busy=0 rereads from the new base.
- rst_n asserted at pixel 6 -> all outputs 0 immediately, no done. A new start yields a full clean frame from pixel 0.
- Macro defined, tp_sel=1, IMG_W=4, IMG_H=3 -> mem_rd_en never 1. Data 0x0000..0x0003, 0x0100..0x0103, 0x0200..0x0203 with the same marker timing as memory mode.
